// File: rtl/wb_stage_if.sv
// Bundle of the write-back stage's upstream handshake, data-memory response
// and register-file / hazard / exception outputs.
interface wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      alu_data;
  logic [XLEN-1:0]      pc_pls4;
  logic [RF_ADDR_W-1:0] rd;
  logic                 reg_wr;
  logic [1:0]           wb_sel;
  logic [2:0]           ld_funct3;
  logic [1:0]           addr_lo;
  logic                 dmem_rsp_valid;
  logic [XLEN-1:0]      dmem_rsp_data;
  logic                 dmem_rsp_err;
  logic                 rf_wr_en;
  logic [RF_ADDR_W-1:0] rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;
  logic                 pend_valid;
  logic [RF_ADDR_W-1:0] pend_rd;
  logic                 exc_valid;
  logic [3:0]           exc_cause;

  // Upstream pipeline plus data memory: drives the instruction and the response.
  modport master (
    output in_valid, alu_data, pc_pls4, rd, reg_wr, wb_sel, ld_funct3, addr_lo,
    output dmem_rsp_valid, dmem_rsp_data, dmem_rsp_err,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  pend_valid, pend_rd, exc_valid, exc_cause
  );

  // The write-back stage itself.
  modport slave (
    input  in_valid, alu_data, pc_pls4, rd, reg_wr, wb_sel, ld_funct3, addr_lo,
    input  dmem_rsp_valid, dmem_rsp_data, dmem_rsp_err,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
    output pend_valid, pend_rd, exc_valid, exc_cause
  );
endinterface

// File: rtl/wb_stage.sv
// Registered RV32I write-back stage: result select, sub-word load alignment and
// extension, variable-latency load wait with timeout, and load exceptions.
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_WAIT_LOAD = 1'b1;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_ACCESS     = 4'd5;

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_wr_en;
  logic [RF_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]      r_wr_data;
  logic                 r_exc_valid;
  logic [3:0]           r_exc_cause;
  logic [RF_ADDR_W-1:0] r_ld_rd;
  logic                 r_ld_reg_wr;
  logic [2:0]           r_ld_funct3;
  logic [1:0]           r_ld_addr_lo;

  logic [0:0]           w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_wr_en_next;
  logic [RF_ADDR_W-1:0] w_wr_addr_next;
  logic [XLEN-1:0]      w_wr_data_next;
  logic                 w_exc_valid_next;
  logic [3:0]           w_exc_cause_next;
  logic [RF_ADDR_W-1:0] w_ld_rd_next;
  logic                 w_ld_reg_wr_next;
  logic [2:0]           w_ld_funct3_next;
  logic [1:0]           w_ld_addr_lo_next;

  logic                 w_accept;
  logic                 w_is_load;
  logic                 w_f3_illegal;
  logic                 w_misaligned;
  logic [XLEN-1:0]      w_sel_data;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [XLEN-1:0]      w_ld_result;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_is_load = (bus.wb_sel == 2'd1);

  assign w_f3_illegal = (bus.ld_funct3 == 3'd3) || (bus.ld_funct3 == 3'd6) ||
                        (bus.ld_funct3 == 3'd7);

  assign w_misaligned = (((bus.ld_funct3 == F3_LH) || (bus.ld_funct3 == F3_LHU)) &&
                         bus.addr_lo[0]) ||
                        ((bus.ld_funct3 == F3_LW) && (bus.addr_lo != 2'b00));

  // Selects 1 (load) never reaches here; 0 and 3 both mean ALU.
  assign w_sel_data = (bus.wb_sel == 2'd2) ? bus.pc_pls4 : bus.alu_data;

  // Lane extraction uses the offset latched at accept, not the live input.
  assign w_byte = bus.dmem_rsp_data[{r_ld_addr_lo, 3'b000} +: 8];
  assign w_half = bus.dmem_rsp_data[{r_ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_result = bus.dmem_rsp_data;
    case (r_ld_funct3)
      F3_LB:   w_ld_result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   w_ld_result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  w_ld_result = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  w_ld_result = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld_result = bus.dmem_rsp_data;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_wr_en_next      = 1'b0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_exc_valid_next  = 1'b0;
    w_exc_cause_next  = r_exc_cause;
    w_ld_rd_next      = r_ld_rd;
    w_ld_reg_wr_next  = r_ld_reg_wr;
    w_ld_funct3_next  = r_ld_funct3;
    w_ld_addr_lo_next = r_ld_addr_lo;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_load) begin
            if (bus.reg_wr && (bus.rd != '0)) begin
              w_wr_en_next   = 1'b1;
              w_wr_addr_next = bus.rd;
              w_wr_data_next = w_sel_data;
            end
          end else if (w_f3_illegal) begin
            w_exc_valid_next = 1'b1;
            w_exc_cause_next = CAUSE_ILLEGAL;
          end else if (w_misaligned) begin
            w_exc_valid_next = 1'b1;
            w_exc_cause_next = CAUSE_MISALIGNED;
          end else begin
            w_state_next      = S_WAIT_LOAD;
            w_cnt_next        = '0;
            w_ld_rd_next      = bus.rd;
            w_ld_reg_wr_next  = bus.reg_wr;
            w_ld_funct3_next  = bus.ld_funct3;
            w_ld_addr_lo_next = bus.addr_lo;
          end
        end
      end
      S_WAIT_LOAD: begin
        // A response is checked first so it beats a same-cycle timeout.
        if (bus.dmem_rsp_valid) begin
          w_state_next = S_IDLE;
          if (bus.dmem_rsp_err) begin
            w_exc_valid_next = 1'b1;
            w_exc_cause_next = CAUSE_ACCESS;
          end else if (r_ld_reg_wr && (r_ld_rd != '0)) begin
            w_wr_en_next   = 1'b1;
            w_wr_addr_next = r_ld_rd;
            w_wr_data_next = w_ld_result;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_next     = S_IDLE;
          w_exc_valid_next = 1'b1;
          w_exc_cause_next = CAUSE_ACCESS;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_exc_valid  <= 1'b0;
      r_exc_cause  <= '0;
      r_ld_rd      <= '0;
      r_ld_reg_wr  <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_addr_lo <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_exc_valid  <= w_exc_valid_next;
      r_exc_cause  <= w_exc_cause_next;
      r_ld_rd      <= w_ld_rd_next;
      r_ld_reg_wr  <= w_ld_reg_wr_next;
      r_ld_funct3  <= w_ld_funct3_next;
      r_ld_addr_lo <= w_ld_addr_lo_next;
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.pend_valid = (r_state == S_WAIT_LOAD);
  assign bus.pend_rd    = r_ld_rd;
  assign bus.rf_wr_en   = r_wr_en;
  assign bus.rf_wr_addr = r_wr_addr;
  assign bus.rf_wr_data = r_wr_data;
  assign bus.exc_valid  = r_exc_valid;
  assign bus.exc_cause  = r_exc_cause;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage for the RV32I core, succeeding the combinational write-back mux. It selects ALU result, PC+4 or load data, aligns and sign/zero-extends sub-word loads, and waits a variable number of cycles for the data-memory response behind a valid/ready handshake. It raises load exceptions (misaligned, access fault, bus timeout) and drives the register-file write port one cycle after the result is known.

## Interface
Parameters:
- XLEN, 32, datapath width (32 only in this generation; byte/half lanes fixed at 8/16).
- RF_ADDR_W, 5, register-file address width.
- TIMEOUT, 64, max cycles spent in WAIT_LOAD before access fault; ≥2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream holds a retiring instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_data  in  XLEN  ALU result.
- pc_pls4  in  XLEN  PC+4 for JAL/JALR.
- rd  in  RF_ADDR_W  destination register.
- reg_wr  in  1  instruction writes rd.
- wb_sel  in  2  0 = ALU, 1 = MEM load, 2 = PC+4, 3 = ALU.
- ld_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- addr_lo  in  2  byte offset of load address (alu_data[1:0]).
- dmem_rsp_valid  in  1  load response present.
- dmem_rsp_data  in  XLEN  raw aligned word from memory.
- dmem_rsp_err  in  1  bus error with response.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_addr  out  RF_ADDR_W  write address.
- rf_wr_data  out  XLEN  write data.
- pend_valid  out  1  load outstanding (WAIT_LOAD).
- pend_rd  out  RF_ADDR_W  rd of outstanding load, for decode hazard stall.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  2 illegal load funct3, 4 load misaligned, 5 load access fault.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept (in_valid & in_ready):
  - wb_sel ≠ 1: capture selected data; rf_wr_en = reg_wr & (rd≠0) next cycle; stay IDLE.
  - wb_sel = 1, ld_funct3 ∈ {3,6,7}: exc cause 2 next cycle; no write; stay IDLE.
  - wb_sel = 1, misaligned (LH/LHU with addr_lo[0]=1, LW with addr_lo≠0): exc cause 4 next cycle; no write; stay IDLE.
  - wb_sel = 1, otherwise: latch rd, reg_wr, funct3, addr_lo; go WAIT_LOAD; clear timeout counter.
- WAIT_LOAD:
  - dmem_rsp_valid & !dmem_rsp_err: extract lane and extend; write next cycle if reg_wr & rd≠0; go IDLE.
    - Byte lane = addr_lo×8; half lane = addr_lo[1]×16.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - dmem_rsp_valid & dmem_rsp_err: exc cause 5 next cycle; no write; go IDLE.
  - No response and counter reaches TIMEOUT−1: exc cause 5 next cycle; go IDLE.
  - Counter increments each cycle without response.
- Response and timeout expiry in the same cycle: response wins.
- dmem_rsp_valid in IDLE is ignored.
- in_valid without in_ready: upstream holds inputs; nothing captured.
- rd = 0 never produces rf_wr_en, even if reg_wr = 1.

## Timing
- All outputs except in_ready, pend_valid and pend_rd are registered.
- in_ready = (state==IDLE); pend_valid = (state==WAIT_LOAD); pend_rd = latched rd.
- Non-load: accept at cycle N → rf_wr_en at N+1. Throughput 1/cycle.
- Load: accept at N → earliest response at N+1 → write at N+2. in_ready low from N+1 until the cycle after the response.
- rf_wr_en and exc_valid are single-cycle pulses, never both high in one cycle.
- rf_wr_addr and rf_wr_data hold their last value when rf_wr_en = 0.
- Reset values:
  - state IDLE; counter 0.
  - rf_wr_en, exc_valid, pend_valid = 0.
  - rf_wr_addr, pend_rd = 0; rf_wr_data = 0; exc_cause = 0.
- Reset during WAIT_LOAD:
  - Load is abandoned; no write or exception is produced.
  - A response arriving after reset is ignored.

## Test plan
- ALU op: rd=5, alu_data=0x1234_5678, wb_sel=0, reg_wr=1 → next cycle rf_wr_en=1, addr 5, data 0x1234_5678. Back-to-back accepts give consecutive writes.
- LB at addr_lo=3, rsp 0x80FF_0000 after 3 wait cycles → write 0xFFFF_FF80 two cycles after accept+3; in_ready low while waiting. LBU on the same response → 0x0000_0080.
- LH at addr_lo=2, rsp 0x8001_1234 → 0xFFFF_8001. LW at addr_lo=1 → exc_valid, cause 4, no write, no WAIT_LOAD.
- Load, no response for TIMEOUT cycles → exc cause 5, state IDLE. Load with dmem_rsp_err=1 → cause 5. Response coinciding with expiry → write, no exception.
- JAL: rd=0, reg_wr=1, wb_sel=2 → no rf_wr_en. JAL: rd=1, pc_pls4=0x104 → write 0x104. ld_funct3=3 → cause 2.
- rst asserted in WAIT_LOAD, response the next cycle → no write, no exception, in_ready=1; all outputs at reset values.
